// File: rtl/fa_pipe_nbit.sv
// fa_pipe_nbit: pipelined N-bit adder/subtractor with valid/ready handshaking.
//
// The operands are split into CHUNK-bit slices (STAGES = WIDTH/CHUNK). Stage k
// adds slice k and hands its carry to stage k+1 through a register. Operand
// slices that are still to be added travel alongside in skew registers, and
// finished result slices travel in deskew registers. Latency is exactly STAGES
// cycles when the pipeline is not stalled. It sustains one operation per cycle.
//
// Parameters:
//   WIDTH  operand/sum width; must be a multiple of CHUNK
//   CHUNK  bits added per pipeline stage (CHUNK == WIDTH gives a single stage)
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset; discards all in-flight operations
//   in_valid   operand bundle valid
//   in_ready   bundle accepted this cycle when in_valid is also high
//   sub        0: s = a + b + ci, 1: s = a - b (a + ~b + 1, ci ignored)
//   a, b       operands, unsigned or two's complement
//   ci         carry-in, add mode only
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   s          sum/difference modulo 2^WIDTH
//   co         carry-out; in subtract mode 1 means no borrow
//   ov         signed overflow (carry into MSB xor carry out of MSB)
module fa_pipe_nbit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ov
);

  localparam int unsigned STAGES = WIDTH / CHUNK;
  localparam int unsigned LAST   = STAGES - 1;

  // Global advance: every stage shifts together, or everything holds.
  logic adv;

  // Per-stage inputs (what stage k sees this cycle).
  logic             vld_in [STAGES];
  logic [WIDTH-1:0] a_in   [STAGES];
  logic [WIDTH-1:0] b_in   [STAGES];
  logic [WIDTH-1:0] res_in [STAGES];
  logic             c_in   [STAGES];

  // Per-stage registers. a/b hold the (effective) operands as skew state,
  // res holds the already finished lower slices, part holds {carry, slice k}.
  logic             vld_d  [STAGES];
  logic             vld_q  [STAGES];
  logic [WIDTH-1:0] a_d    [STAGES];
  logic [WIDTH-1:0] a_q    [STAGES];
  logic [WIDTH-1:0] b_d    [STAGES];
  logic [WIDTH-1:0] b_q    [STAGES];
  logic [WIDTH-1:0] res_d  [STAGES];
  logic [WIDTH-1:0] res_q  [STAGES];
  logic [CHUNK:0]   part_d [STAGES];
  logic [CHUNK:0]   part_q [STAGES];

  logic             ov_d;
  logic             ov_q;
  logic [WIDTH-1:0] s_full;

  always_comb begin
    adv = !vld_q[LAST] || out_ready;

    // Stage 0 is fed straight from the ports. Subtraction is folded in here
    // once so that later stages only ever add.
    vld_in[0] = in_valid;
    a_in[0]   = a;
    b_in[0]   = sub ? ~b : b;
    c_in[0]   = sub ? 1'b1 : ci;
    res_in[0] = '0;

    // Stage k takes the carry from stage k-1 and merges the slice that stage
    // k-1 finished into the deskewed result.
    for (int unsigned k = 1; k < STAGES; k++) begin
      vld_in[k] = vld_q[k-1];
      a_in[k]   = a_q[k-1];
      b_in[k]   = b_q[k-1];
      c_in[k]   = part_q[k-1][CHUNK];
      res_in[k] = res_q[k-1];
      res_in[k][(k-1)*CHUNK +: CHUNK] = part_q[k-1][CHUNK-1:0];
    end

    for (int unsigned k = 0; k < STAGES; k++) begin
      vld_d[k]  = vld_in[k];
      a_d[k]    = a_in[k];
      b_d[k]    = b_in[k];
      res_d[k]  = res_in[k];
      part_d[k] = {1'b0, a_in[k][k*CHUNK +: CHUNK]}
                + {1'b0, b_in[k][k*CHUNK +: CHUNK]}
                + {{CHUNK{1'b0}}, c_in[k]};
    end

    // Carry into the MSB is recovered from the MSB sum bit and its operands.
    ov_d = (a_in[LAST][WIDTH-1] ^ b_in[LAST][WIDTH-1] ^ part_d[LAST][CHUNK-1])
         ^ part_d[LAST][CHUNK];

    // Output is pure wiring of final-stage registers.
    s_full = res_q[LAST];
    s_full[LAST*CHUNK +: CHUNK] = part_q[LAST][CHUNK-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        vld_q[k]  <= 1'b0;
        a_q[k]    <= '0;
        b_q[k]    <= '0;
        res_q[k]  <= '0;
        part_q[k] <= '0;
      end
      ov_q <= 1'b0;
    end else if (adv) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        vld_q[k]  <= vld_d[k];
        a_q[k]    <= a_d[k];
        b_q[k]    <= b_d[k];
        res_q[k]  <= res_d[k];
        part_q[k] <= part_d[k];
      end
      ov_q <= ov_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = vld_q[LAST];
  assign s         = s_full;
  assign co        = part_q[LAST][CHUNK];
  assign ov        = ov_q;

endmodule

// File: tb/tb_fa_pipe_nbit.sv
module tb_fa_pipe_nbit;

  typedef struct {
    logic [15:0] s;
    logic        co;
    logic        ov;
    int          acc;
    bit          chk_lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready, sub, ci;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;

  logic        ird  [3];
  logic        ovld [3];
  logic        oco  [3];
  logic        oov  [3];
  logic [15:0] os   [3];
  logic [7:0]  s0, s2;
  logic [15:0] s1;

  assign os[0] = {8'h00, s0};
  assign os[1] = s1;
  assign os[2] = {8'h00, s2};

  fa_pipe_nbit #(.WIDTH(8), .CHUNK(4)) u_d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ird[0]), .sub(sub),
    .a(a8), .b(b8), .ci(ci), .out_valid(ovld[0]), .out_ready(out_ready),
    .s(s0), .co(oco[0]), .ov(oov[0]));

  fa_pipe_nbit #(.WIDTH(16), .CHUNK(4)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ird[1]), .sub(sub),
    .a(a16), .b(b16), .ci(ci), .out_valid(ovld[1]), .out_ready(out_ready),
    .s(s1), .co(oco[1]), .ov(oov[1]));

  fa_pipe_nbit #(.WIDTH(8), .CHUNK(8)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ird[2]), .sub(sub),
    .a(a8), .b(b8), .ci(ci), .out_valid(ovld[2]), .out_ready(out_ready),
    .s(s2), .co(oco[2]), .ov(oov[2]));

  int unsigned wid [3] = '{8, 16, 8};
  int          stg [3] = '{2, 4, 1};

  int   npass = 0;
  int   ntot  = 0;
  int   cyc   = 0;
  bit   ordy_always = 1'b1;
  exp_t sbq [3][$];

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic and the sign rules for overflow.
  function automatic exp_t model(int unsigned w, bit sb, logic [15:0] x,
                                 logic [15:0] y, bit c);
    exp_t e;
    longint unsigned mask, xl, yl, full;
    bit sx, sy, ss;
    mask = (64'd1 << w) - 64'd1;
    xl = 64'(x);
    yl = 64'(y);
    if (!sb) begin
      full = xl + yl + 64'(c);
      e.co = ((full >> w) & 64'd1) != 0;
    end else begin
      full = (xl - yl) & mask;
      e.co = (xl >= yl);
    end
    e.s = 16'(full & mask);
    sx = x[w-1];
    sy = y[w-1];
    ss = e.s[w-1];
    e.ov = sb ? (sx != sy && ss != sx) : (sx == sy && ss != sx);
    e.acc = 0;
    e.chk_lat = 1'b0;
    return e;
  endfunction

  task automatic chk(string nm, int i, longint act, longint expv);
    ntot++;
    if (act == expv) npass++;
    else $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)",
                  nm, i, act, expv, cyc);
  endtask

  // Monitor / scoreboard, sampled on the falling edge.
  bit          rst_prev = 1'b0;
  bit          prev_stall [3] = '{0, 0, 0};
  logic [15:0] prev_s  [3];
  logic        prev_co [3];
  logic        prev_ov [3];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst_prev) begin
        chk("rst_out_valid", i, longint'(ovld[i]), 0);
        chk("rst_s", i, longint'(os[i]), 0);
        chk("rst_in_ready", i, longint'(ird[i]), 1);
      end else begin
        if (prev_stall[i]) begin
          chk("stall_valid", i, longint'(ovld[i]), 1);
          chk("stall_s", i, longint'(os[i]), longint'(prev_s[i]));
          chk("stall_co", i, longint'(oco[i]), longint'(prev_co[i]));
          chk("stall_ov", i, longint'(oov[i]), longint'(prev_ov[i]));
        end
        chk("in_ready", i, longint'(ird[i]), longint'(!ovld[i] || out_ready));
      end
      if (!rst) begin
        if (ovld[i] && out_ready) begin
          if (sbq[i].size() == 0) begin
            ntot++;
            $display("FAIL unexpected_out dut%0d: got s=%0h with no result pending (cycle %0d)",
                     i, os[i], cyc);
          end else begin
            exp_t e;
            e = sbq[i].pop_front();
            chk("s", i, longint'(os[i]), longint'(e.s));
            chk("co", i, longint'(oco[i]), longint'(e.co));
            chk("ov", i, longint'(oov[i]), longint'(e.ov));
            if (e.chk_lat) chk("latency", i, longint'(cyc - e.acc), longint'(stg[i]));
          end
        end
        if (in_valid && ird[i]) begin
          exp_t e;
          if (i == 1) e = model(wid[i], sub, a16, b16, ci);
          else        e = model(wid[i], sub, {8'h00, a8}, {8'h00, b8}, ci);
          e.acc = cyc;
          e.chk_lat = ordy_always;
          sbq[i].push_back(e);
        end
        prev_stall[i] = ovld[i] && !out_ready;
      end else begin
        sbq[i].delete();
        prev_stall[i] = 1'b0;
      end
      prev_s[i]  = os[i];
      prev_co[i] = oco[i];
      prev_ov[i] = oov[i];
    end
    rst_prev = rst;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(bit sb, logic [7:0] x, logic [7:0] y, bit c,
                      logic [15:0] x16, logic [15:0] y16);
    in_valid = 1'b1;
    sub = sb;
    a8 = x;
    b8 = y;
    ci = c;
    a16 = x16;
    b16 = y16;
    step();
  endtask

  task automatic idle(int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    int budget;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sub = 1'b0; ci = 1'b0;
    a8 = '0; b8 = '0; a16 = '0; b16 = '0;
    repeat (2) step();
    rst = 1'b0;
    step();

    send(0, 8'hFF, 8'h01, 0, 16'hFFFF, 16'h0001);
    idle(5);
    send(0, 8'h7F, 8'h01, 0, 16'h7FFF, 16'h0001);
    send(0, 8'h80, 8'hFF, 0, 16'h8000, 16'hFFFF);
    idle(5);
    send(1, 8'h10, 8'h01, 1, 16'h0100, 16'h0001);
    send(1, 8'h00, 8'h01, 0, 16'h0000, 16'h0001);
    idle(5);
    send(0, 8'd3, 8'd4, 1, 16'd3, 16'd4);
    send(0, 8'd200, 8'd100, 0, 16'd60000, 16'd6000);
    send(0, 8'd15, 8'd1, 1, 16'd15, 16'd1);
    idle(6);

    // Reset one cycle after acceptance: the result must never appear.
    send(0, 8'h12, 8'h34, 0, 16'h1234, 16'h4321);
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle(6);

    // Backpressure with results queued up in the pipeline.
    ordy_always = 1'b0;
    out_ready = 1'b0;
    send(0, 8'h21, 8'h43, 0, 16'h2143, 16'h0101);
    send(1, 8'h05, 8'h09, 0, 16'h0005, 16'h0009);
    send(0, 8'hC0, 8'hC0, 1, 16'hC000, 16'hC000);
    idle(3);
    out_ready = 1'b1;
    idle(8);

    repeat (600) begin
      rst       = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 60);
      sub = 1'($urandom);
      ci  = 1'($urandom);
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      step();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;

    budget = 0;
    while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0 && budget < 50) begin
      step();
      budget++;
    end
    step();
    chk("drain_pending", 0, longint'(sbq[0].size() + sbq[1].size() + sbq[2].size()), 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/fa_pipe_nbit.md
Name: fa_pipe_nbit

Overview:
- Parametrised, pipelined N-bit adder/subtractor; next generation after the 1-bit and 4-bit full adders.
- Operand width is split into CHUNK-bit slices. Each pipeline stage adds one slice, and the carry ripples stage to stage through registers.
- Adds valid/ready handshaking, backpressure, a subtract mode and a signed-overflow flag.
- Sits between operand producers and consumers in the datapath; sustains one operation per cycle.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per pipeline stage; STAGES = WIDTH/CHUNK is derived, not a parameter.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand bundle valid
- in_ready  out  1  block accepts the bundle this cycle
- sub  in  1  0 = a+b+ci; 1 = a-b (computed as a+~b+1; ci ignored)
- a  in  WIDTH  operand A, unsigned/two's complement
- b  in  WIDTH  operand B
- ci  in  1  carry-in (add mode only)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- s  out  WIDTH  sum/difference
- co  out  1  carry-out; in sub mode, 1 = no borrow
- ov  out  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset: synchronous on the rising edge with rst=1. Clears all stage valid bits, s=0, co=0, ov=0, out_valid=0. Data registers clear to 0.
- Reset takes priority over any handshake in the same cycle. In-flight operations are discarded, never emitted. in_ready=1 in the first cycle after reset.
- Advance: adv = !out_valid || out_ready, and in_ready = adv (combinational). Advance is global: all stages shift together when adv=1 and hold all registers when adv=0.
- Acceptance: a bundle is accepted when in_valid && in_ready. Stage-0 valid is loaded with in_valid on every advance, so bubbles propagate as valid=0.
- Stage k (0..STAGES-1):
  - Adds slice k of a and b_eff (b_eff = sub ? ~b : b) with the carry from stage k-1.
  - Carry into stage 0 is sub ? 1 : ci.
  - Slices above k travel in skew registers alongside. Result slices below k travel in deskew registers.
  - Each stage holds its own (CHUNK+1)-bit partial result.
- Latency: exactly STAGES cycles from acceptance to out_valid=1 when not stalled; STAGES=2 at defaults.
  - Throughput is 1 op/cycle with out_ready=1.
  - Results emerge in acceptance order.
- Output: s/co/ov are registered in the final stage. While out_valid=1 && out_ready=0 they are held stable and unchanged.
- Overflow: ov is computed in the last stage from the carry into bit WIDTH-1 and co. It is meaningful only as a signed result; no saturation.
- Wrap-around: s is the sum modulo 2^WIDTH; the excess appears only on co.
- Simultaneous accept and emit in the same cycle (adv=1) is legal; there is no loss and no duplication.
- Stall with a bubble in flight: a global stall also freezes bubbles. Bubble compression is not required.
- STAGES=1 (CHUNK=WIDTH) is a legal configuration: a single registered adder with latency 1.

Test Plan:
- Carry across the slice boundary (defaults): a=8'hFF, b=8'h01, ci=0, sub=0 → 2 cycles later s=8'h00, co=1, ov=0, out_valid=1 for one cycle.
- Signed overflow: a=8'h7F, b=8'h01, ci=0 → s=8'h80, co=0, ov=1. Then a=8'h80, b=8'hFF → s=8'h7F, co=1, ov=1.
- Subtract: sub=1, a=8'h10, b=8'h01, ci=1 (ignored) → s=8'h0F, co=1, ov=0. Then sub=1, a=8'h00, b=8'h01 → s=8'hFF, co=0 (borrow), ov=0.
- Back-to-back with ci: out_ready=1, three consecutive accepts (3+4+ci1, 200+100+0, 15+1+1) → s=8, 44 with co=1, 17 on three consecutive cycles in that order.
- Backpressure: hold out_ready=0 for 3 cycles while a result is valid → s/co/ov/out_valid stable and in_ready=0. Release → all queued results emerge in order; none lost or duplicated.
- Reset mid-flight: assert rst one cycle after accepting 8'h12+8'h34 → out_valid=0, s=0 the next cycle; no result 8'h46 ever appears. Repeat with WIDTH=16, CHUNK=4: 16'hFFFF+16'h0001 → s=0, co=1 after 4 cycles.
